// File: rtl/clock_divider_prog.sv
// ============================================================================
// Module      : clock_divider_prog
// Description : Programmable divide-by-N clock divider (N = 2..2^CNT_W-1)
//               with glitch-free start/stop, boundary-aligned ratio reload
//               and a rising-edge tick. Optional macro ODD_DUTY50_EN adds a
//               negedge flop so odd ratios produce an exact 50% duty cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module clock_divider_prog #(
    parameter int CNT_W       = 8,
    parameter int DIV_DEFAULT = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack,
    output logic             ratio_err,
    output logic             running
);

    localparam logic [0:0]       c_st_idle     = 1'b0;
    localparam logic [0:0]       c_st_run      = 1'b1;
    localparam logic [CNT_W-1:0] c_min_ratio   = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_div_default = CNT_W'(DIV_DEFAULT);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ratio;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_q_pos;
    logic             r_tick;
    logic             r_load_ack;
    logic             r_ratio_err;
    logic             r_running;

    logic [CNT_W-1:0] w_load_ratio;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_next_ratio;
    logic             w_terminal;

    assign w_load_ratio = (div_ratio < c_min_ratio) ? c_min_ratio : div_ratio;
    assign w_cnt_inc    = r_cnt + c_one;
    assign w_terminal   = (r_cnt == (r_ratio - c_one));
    // A load landing in the terminal cycle wins over an older pending ratio.
    assign w_next_ratio = load ? w_load_ratio : (r_pend_vld ? r_pend : r_ratio);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_ratio     <= c_div_default;
            r_pend      <= '0;
            r_pend_vld  <= 1'b0;
            r_q_pos     <= 1'b0;
            r_tick      <= 1'b0;
            r_load_ack  <= 1'b0;
            r_ratio_err <= 1'b0;
            r_running   <= 1'b0;
        end else begin
            r_ratio_err <= load && (div_ratio < c_min_ratio);
            r_tick      <= 1'b0;
            r_load_ack  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_cnt      <= '0;
                    r_pend_vld <= 1'b0;
                    if (load) begin
                        r_ratio    <= w_load_ratio;
                        r_load_ack <= 1'b1;
                    end
                    if (en) begin
                        r_state   <= c_st_run;
                        r_q_pos   <= 1'b1;
                        r_tick    <= 1'b1;
                        r_running <= 1'b1;
                    end else begin
                        r_q_pos   <= 1'b0;
                        r_running <= 1'b0;
                    end
                end
                c_st_run: begin
                    if (w_terminal) begin
                        r_cnt      <= '0;
                        r_ratio    <= w_next_ratio;
                        r_load_ack <= load || r_pend_vld;
                        r_pend_vld <= 1'b0;
                        if (en) begin
                            r_q_pos <= 1'b1;
                            r_tick  <= 1'b1;
                        end else begin
                            r_state   <= c_st_idle;
                            r_q_pos   <= 1'b0;
                            r_running <= 1'b0;
                        end
                    end else begin
                        r_cnt   <= w_cnt_inc;
                        r_q_pos <= (w_cnt_inc < (r_ratio >> 1));
                        if (load) begin
                            r_pend     <= w_load_ratio;
                            r_pend_vld <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_q_pos   <= 1'b0;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

`ifdef ODD_DUTY50_EN
    // Half-cycle delayed copy of the high phase; stretches odd-N highs by 0.5.
    logic r_q_neg;

    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_q_neg <= 1'b0;
        end else if (r_state == c_st_idle) begin
            r_q_neg <= 1'b0;
        end else begin
            r_q_neg <= r_q_pos;
        end
    end

    assign clk_out = r_q_pos | (r_ratio[0] & r_q_neg);
`else
    assign clk_out = r_q_pos;
`endif

    assign tick      = r_tick;
    assign load_ack  = r_load_ack;
    assign ratio_err = r_ratio_err;
    assign running   = r_running;

endmodule

`default_nettype wire
